// File: rtl/rv32_mod_muldiv_seq.sv
// rv32_mod_muldiv_seq: multi-cycle RV32M sequencer.
// Iterative MSB-first shift-add multiplier and restoring divider working on
// operand magnitudes, with a final sign fix-up step and a valid/ready request
// handshake. Stall is raised towards the core while an M operation is in flight.
`timescale 1ns/1ps
module rv32_mod_muldiv_seq #(
   parameter int UNROLL = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  func,
   input  logic [31:0] read0_data,
   input  logic [31:0] read1_data,
   input  logic        flush,
   output logic        resp_valid,
   output logic [31:0] result,
   output logic        stall
);

   localparam int N  = 32 / UNROLL;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    func_q, func_d;
   logic          neg_q, neg_d;
   logic          spec_q, spec_d;
   logic [31:0]   spec_val_q, spec_val_d;
   logic [31:0]   opa_q, opa_d;      // multiplicand, or dividend/quotient shift register
   logic [31:0]   opb_q, opb_d;      // multiplier shift register, or divisor
   logic [63:0]   acc_q, acc_d;      // product accumulator, or remainder in [31:0]
   logic          resp_valid_q, resp_valid_d;
   logic [31:0]   result_q, result_d;

   logic          sgn_a_s, sgn_b_s, neg_s;
   logic [31:0]   mag_a_s, mag_b_s;
   logic          div_zero_s, ovf_s, spec_s;
   logic [31:0]   spec_val_s;
   logic          accept_s;
   logic [63:0]   step_acc_s;
   logic [31:0]   step_opa_s, step_opb_s;
   logic [63:0]   prod_s;
   logic [31:0]   quo_s, rem_s, fix_val_s;

   assign req_ready  = rstn && (state_q == S_IDLE) && !flush;
   assign stall      = rstn && (req_valid || (state_q == S_CALC) || (state_q == S_FIX));
   assign accept_s   = req_valid && req_ready;
   assign resp_valid = resp_valid_q;
   assign result     = result_q;

   // Operand sign conditioning, negate flag and special-case detection at accept.
   always_comb begin
      sgn_a_s = 1'b0;
      sgn_b_s = 1'b0;
      case (func)
         F_MUL, F_MULH, F_DIV, F_REM: begin
            sgn_a_s = read0_data[31];
            sgn_b_s = read1_data[31];
         end
         F_MULHSU: begin
            sgn_a_s = read0_data[31];
            sgn_b_s = 1'b0;
         end
         default: begin
            sgn_a_s = 1'b0;
            sgn_b_s = 1'b0;
         end
      endcase
      // 0x80000000 negates to itself, which is the correct unsigned magnitude.
      mag_a_s    = sgn_a_s ? (32'd0 - read0_data) : read0_data;
      mag_b_s    = sgn_b_s ? (32'd0 - read1_data) : read1_data;
      neg_s      = (func == F_REM) ? sgn_a_s : (sgn_a_s ^ sgn_b_s);
      div_zero_s = func[2] && (read1_data == 32'd0);
      ovf_s      = func[2] && !func[0] && (read0_data == 32'h8000_0000)
                   && (read1_data == 32'hFFFF_FFFF);
      spec_s     = div_zero_s || ovf_s;
      if (div_zero_s) begin
         spec_val_s = func[1] ? read0_data : 32'hFFFF_FFFF;
      end else if (ovf_s) begin
         spec_val_s = func[1] ? 32'd0 : 32'h8000_0000;
      end else begin
         spec_val_s = 32'd0;
      end
   end

   // One CALC cycle worth of UNROLL multiply or divide steps.
   always_comb begin : step_p
      logic [63:0] acc_v;
      logic [31:0] mb_v;
      logic [31:0] rem_v;
      logic [31:0] quo_v;
      logic [32:0] t_v;
      acc_v = acc_q;
      mb_v  = opb_q;
      rem_v = acc_q[31:0];
      quo_v = opa_q;
      t_v   = 33'd0;
      for (int i = 0; i < UNROLL; i++) begin
         // multiply: MSB-first shift-add
         acc_v = {acc_v[62:0], 1'b0} + {32'd0, (mb_v[31] ? opa_q : 32'd0)};
         mb_v  = {mb_v[30:0], 1'b0};
         // divide: restoring, dividend bits shift out as quotient bits shift in
         t_v   = {rem_v, quo_v[31]};
         quo_v = {quo_v[30:0], 1'b0};
         if (t_v >= {1'b0, opb_q}) begin
            rem_v    = t_v[31:0] - opb_q;
            quo_v[0] = 1'b1;
         end else begin
            rem_v    = t_v[31:0];
         end
      end
      if (func_q[2]) begin
         step_acc_s = {32'd0, rem_v};
         step_opa_s = quo_v;
         step_opb_s = opb_q;
      end else begin
         step_acc_s = acc_v;
         step_opa_s = opa_q;
         step_opb_s = mb_v;
      end
   end

   // Sign fix-up and result selection for the FIX state.
   always_comb begin
      prod_s = neg_q ? (64'd0 - acc_q) : acc_q;
      quo_s  = neg_q ? (32'd0 - opa_q) : opa_q;
      rem_s  = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
      case (func_q)
         F_MUL:                    fix_val_s = prod_s[31:0];
         F_MULH, F_MULHSU, F_MULHU: fix_val_s = prod_s[63:32];
         F_DIV, F_DIVU:            fix_val_s = quo_s;
         default:                  fix_val_s = rem_s;
      endcase
   end

   // Next-state and datapath register updates.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      func_d       = func_q;
      neg_d        = neg_q;
      spec_d       = spec_q;
      spec_val_d   = spec_val_q;
      opa_d        = opa_q;
      opb_d        = opb_q;
      acc_d        = acc_q;
      resp_valid_d = 1'b0;
      result_d     = result_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               func_d     = func;
               neg_d      = neg_s;
               spec_d     = spec_s;
               spec_val_d = spec_val_s;
               opa_d      = mag_a_s;
               opb_d      = mag_b_s;
               acc_d      = 64'd0;
               cnt_d      = '0;
               state_d    = spec_s ? S_FIX : S_CALC;
            end else begin
               state_d    = S_IDLE;
            end
         end
         S_CALC: begin
            if (flush) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               acc_d = step_acc_s;
               opa_d = step_opa_s;
               opb_d = step_opb_s;
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = S_FIX;
               end else begin
                  cnt_d   = cnt_q + CW'(1);
               end
            end
         end
         S_FIX: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               result_d     = spec_q ? spec_val_q : fix_val_s;
               resp_valid_d = 1'b1;
               state_d      = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         func_q       <= 3'd0;
         neg_q        <= 1'b0;
         spec_q       <= 1'b0;
         spec_val_q   <= 32'd0;
         opa_q        <= 32'd0;
         opb_q        <= 32'd0;
         acc_q        <= 64'd0;
         resp_valid_q <= 1'b0;
         result_q     <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         func_q       <= func_d;
         neg_q        <= neg_d;
         spec_q       <= spec_d;
         spec_val_q   <= spec_val_d;
         opa_q        <= opa_d;
         opb_q        <= opb_d;
         acc_q        <= acc_d;
         resp_valid_q <= resp_valid_d;
         result_q     <= result_d;
      end
   end

endmodule

// File: tb/tb_rv32_mod_muldiv_seq.sv
// tb_rv32_mod_muldiv_seq: directed and small random bench for the RV32M sequencer,
// with a result scoreboard queue and cycle-accurate latency checks.
`timescale 1ns/1ps
module tb_rv32_mod_muldiv_seq;

   logic        clk = 1'b0;
   logic        rstn, req_valid, req_valid2, req_valid4, flush;
   logic [2:0]  func;
   logic [31:0] rd0, rd1;
   logic        req_ready, resp_valid, stall;
   logic [31:0] result;
   logic        req_ready2, resp_valid2, stall2;
   logic [31:0] result2;
   logic        req_ready4, resp_valid4, stall4;
   logic [31:0] result4;

   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   int          last_done_cyc = 0;
   logic [31:0] last_res = 32'd0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rv32_mod_muldiv_seq #(.UNROLL(1)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
      .func(func), .read0_data(rd0), .read1_data(rd1), .flush(flush),
      .resp_valid(resp_valid), .result(result), .stall(stall));

   rv32_mod_muldiv_seq #(.UNROLL(2)) dut2 (
      .clk(clk), .rstn(rstn), .req_valid(req_valid2), .req_ready(req_ready2),
      .func(func), .read0_data(rd0), .read1_data(rd1), .flush(flush),
      .resp_valid(resp_valid2), .result(result2), .stall(stall2));

   rv32_mod_muldiv_seq #(.UNROLL(4)) dut4 (
      .clk(clk), .rstn(rstn), .req_valid(req_valid4), .req_ready(req_ready4),
      .func(func), .read0_data(rd0), .read1_data(rd1), .flush(flush),
      .resp_valid(resp_valid4), .result(result4), .stall(stall4));

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp_v);
      n_chk++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
      end
   endtask

   // Reference: architectural RV32M semantics.
   function automatic logic [31:0] ref_m(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sp;
      logic [63:0]        up;
      logic signed [31:0] sa, sb, sq;
      sa = a;
      sb = b;
      case (f)
         3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
         3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
         3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return sp[63:32]; end
         3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            sq = sa / sb; return sq;
         end
         3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            sq = sa % sb; return sq;
         end
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_spec(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   // Present a request on the UNROLL=1 instance (called at a falling edge);
   // returns the accept cycle and scrambles inputs right after the accept edge.
   task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input string tag, output int a_cyc);
      int t;
      func = f; rd0 = a; rd1 = b; req_valid = 1'b1;
      #1;
      t = 0;
      while (!req_ready && t < 50) begin
         @(negedge clk); #1; t++;
      end
      chk1({tag, "_ready"}, req_ready, 1'b1);
      chk1({tag, "_stall_a"}, stall, 1'b1);
      a_cyc = cyc;
      @(posedge clk);
      #1;
      func = 3'($urandom_range(0, 7)); rd0 = $urandom; rd1 = $urandom;
   endtask

   // Wait for the response, check latency, stall, scoreboard result, one-cycle strobe.
   task automatic wait_resp(input int a_cyc, input int lat, input string tag);
      int t;
      bit stall_bad;
      logic [31:0] e;
      t = 0;
      stall_bad = 0;
      do begin
         @(negedge clk);
         t++;
         if (!resp_valid && !stall) stall_bad = 1;
      end while (!resp_valid && t < 200);
      chk1({tag, "_resp"}, resp_valid, 1'b1);
      chk32({tag, "_lat"}, 32'(cyc - a_cyc), 32'(lat));
      chk1({tag, "_stall_busy"}, stall_bad, 1'b0);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk32({tag, "_result"}, result, e);
         last_res = e;
      end else begin
         chk1({tag, "_sb_empty"}, 1'b1, 1'b0);
      end
      last_done_cyc = cyc;
      req_valid = 1'b0;
      @(negedge clk);
      chk1({tag, "_strobe"}, resp_valid, 1'b0);
      chk32({tag, "_hold"}, result, last_res);
      chk1({tag, "_stall_idle"}, stall, 1'b0);
   endtask

   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int lat, input string tag);
      int a_c;
      start_op(f, a, b, tag, a_c);
      exp_q.push_back(e);
      wait_resp(a_c, lat, tag);
   endtask

   // One op on the UNROLL=2 (w==2) or UNROLL=4 instance.
   task automatic run_w(input int w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input int lat, input string tag);
      int a_c, t;
      logic got;
      logic [31:0] pe;
      func = f; rd0 = a; rd1 = b;
      if (w == 2) req_valid2 = 1'b1; else req_valid4 = 1'b1;
      #1;
      chk1({tag, "_ready"}, (w == 2) ? req_ready2 : req_ready4, 1'b1);
      a_c = cyc;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      func = 3'($urandom_range(0, 7)); rd0 = $urandom; rd1 = $urandom;
      t = 0;
      got = 1'b0;
      while (!got && t < 100) begin
         @(negedge clk); t++;
         got = (w == 2) ? resp_valid2 : resp_valid4;
      end
      chk1({tag, "_resp"}, got, 1'b1);
      chk32({tag, "_lat"}, 32'(cyc - a_c), 32'(lat));
      pe = (exp_q.size() > 0) ? exp_q.pop_front() : ~e;
      chk32({tag, "_result"}, (w == 2) ? result2 : result4, pe);
      req_valid2 = 1'b0; req_valid4 = 1'b0;
      @(negedge clk);
      chk1({tag, "_strobe"}, (w == 2) ? resp_valid2 : resp_valid4, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int fa, a_c;
      logic [2:0] f;
      logic [31:0] a, b;
      rstn = 1'b0; req_valid = 1'b1; req_valid2 = 1'b0; req_valid4 = 1'b0;
      flush = 1'b0; func = 3'd0; rd0 = 32'd0; rd1 = 32'd0;
      repeat (2) @(negedge clk);
      chk1("rst_resp_valid", resp_valid, 1'b0);
      chk32("rst_result", result, 32'd0);
      chk1("rst_req_ready", req_ready, 1'b0);
      chk1("rst_stall", stall, 1'b0);
      req_valid = 1'b0;
      @(negedge clk); rstn = 1'b1;
      @(negedge clk);

      // Multiply and divide, UNROLL=1, latency N+2 = 34
      run_op(3'd0, 32'hFFFF_FFFF, 32'd7,          32'hFFFF_FFF9, 34, "mul_m1x7");
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 34, "mulh_min");
      run_op(3'd2, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 34, "mulhsu");
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 34, "mulhu");
      run_op(3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB,  32'd15,        34, "mul_neg_neg");
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 34, "div_m7_2");
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 34, "rem_m7_2");
      run_op(3'd6, 32'd7,         32'hFFFF_FFFE,  32'd1,         34, "rem_7_m2");
      run_op(3'd5, 32'd100,       32'd7,          32'd14,        34, "divu_100_7");
      // back-to-back: next accept in the cycle after DONE
      start_op(3'd7, 32'd100, 32'd7, "remu_100_7", a_c);
      chk32("b2b_accept", 32'(a_c), 32'(last_done_cyc + 1));
      exp_q.push_back(32'd2);
      wait_resp(a_c, 34, "remu_100_7");

      // Special-case early-out, latency 2
      run_op(3'd4, 32'd1234,      32'd0,          32'hFFFF_FFFF, 2, "div_by0");
      run_op(3'd5, 32'd1234,      32'd0,          32'hFFFF_FFFF, 2, "divu_by0");
      run_op(3'd6, 32'd5,         32'd0,          32'd5,         2, "rem_by0");
      run_op(3'd7, 32'd9,         32'd0,          32'd9,         2, "remu_by0");
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 2, "div_ovf");
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         2, "rem_ovf");

      // flush mid-CALC, then a new op accepted the next cycle
      start_op(3'd5, 32'd1000, 32'd3, "flush_divu", fa);
      while (cyc < fa + 10) begin
         @(negedge clk);
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk1("flush_ready", req_ready, 1'b1);
      chk1("flush_no_resp", resp_valid, 1'b0);
      chk32("flush_result_kept", result, last_res);
      start_op(3'd0, 32'd3, 32'd4, "flush_mul", a_c);
      chk32("flush_accept_cyc", 32'(a_c), 32'(fa + 11));
      exp_q.push_back(32'd12);
      wait_resp(a_c, 34, "flush_mul");

      // flush together with req_valid in IDLE: no accept
      flush = 1'b1; req_valid = 1'b1; func = 3'd0; rd0 = 32'd2; rd1 = 32'd2;
      #1;
      chk1("idle_flush_ready", req_ready, 1'b0);
      @(negedge clk);
      flush = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      chk1("idle_flush_no_accept", stall, 1'b0);

      // async reset mid-CALC
      start_op(3'd0, 32'd5, 32'd6, "rst_mid", a_c);
      repeat (5) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      chk1("rst_mid_resp_valid", resp_valid, 1'b0);
      chk32("rst_mid_result", result, 32'd0);
      chk1("rst_mid_stall", stall, 1'b0);
      req_valid = 1'b0;
      @(negedge clk); rstn = 1'b1;
      @(negedge clk);
      run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, "post_rst_div");

      // UNROLL=2 (N=16) and UNROLL=4 (N=8)
      run_w(2, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 18, "u2_mulhu");
      run_w(2, 3'd0, 32'hFFFF_FFFF, 32'd7,         32'hFFFF_FFF9, 18, "u2_mul");
      run_w(2, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2,  "u2_div_ovf");
      run_w(4, 3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 10, "u4_div");
      run_w(4, 3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 10, "u4_rem");
      run_w(4, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 10, "u4_mulh");

      // random operands against the reference
      for (int i = 0; i < 10; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
         run_op(f, a, b, ref_m(f, a, b), is_spec(f, a, b) ? 2 : 34, "rand_u1");
      end
      for (int i = 0; i < 6; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         run_w(4, f, a, b, ref_m(f, a, b), is_spec(f, a, b) ? 2 : 10, "rand_u4");
      end

      chk32("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
